exmpipe: RTL and testbench

- Execute stage plus Execute-Memory pipeline register. Consumes the decoded operands/control leaving the D/E register, applies forwarding, computes the ALU result and registers it with control for the memory stage.
- Single-cycle ops pass through in one cycle. MUL uses an iterative shift-add unit and stalls the front end via stall_E.

---
 rtl/proc_pkg.sv | 93 +++++++++
 rtl/mul_iter.sv | 60 ++++++
 rtl/exmpipe.sv | 159 +++++++++++++++
 tb/tb_exmpipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types, widths and ALU helpers for the execute stage and its E/M register.
package proc_pkg;

  localparam int unsigned N   = 32;
  localparam int unsigned M   = 4;
  localparam int unsigned L   = 3;
  localparam int unsigned SHW = $clog2(N);
  localparam int unsigned CW  = $clog2(N);

  typedef enum logic [L-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } exm_state_t;

  typedef struct packed {
    logic         regw;
    logic         memw;
    logic         regmem;
    logic [M-1:0] regscr;
    logic [N-1:0] aluout;
    logic [N-1:0] wdata;
  } em_t;

  // Control and store data parked while a multiply runs
  typedef struct packed {
    logic         regw;
    logic         memw;
    logic         regmem;
    logic [M-1:0] regscr;
    logic [N-1:0] wdata;
  } mul_ctl_t;

  // Select code 11 falls back to the register operand
  function automatic logic [N-1:0] fwd_mux(input logic [1:0] sel, input logic [N-1:0] rf,
                                           input logic [N-1:0] mem, input logic [N-1:0] wb);
    logic [N-1:0] v;
    case (sel)
      FWD_MEM: v = mem;
      FWD_WB:  v = wb;
      default: v = rf;
    endcase
    return v;
  endfunction

  function automatic logic [N-1:0] alu_eval(input alu_op_t op, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
    logic [SHW-1:0] sh;
    logic [N-1:0]   r;
    sh = b[SHW-1:0];
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLL: r = a << sh;
      ALU_SRL: r = a >> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Carry-out of ADD, borrow-not of SUB, zero for everything else
  function automatic logic alu_carry(input alu_op_t op, input logic [N-1:0] a,
                                     input logic [N-1:0] b);
    logic [N:0] s;
    case (op)
      ALU_ADD: s = {1'b0, a} + {1'b0, b};
      ALU_SUB: s = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
      default: s = '0;
    endcase
    return s[N];
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low N bits of the product kept.
module mul_iter
  import proc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done_c,
  output logic [N-1:0] product
);

  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(N-1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign done_c  = busy_q && (cnt_q == CW'(N-1));
  assign product = acc_q;

endmodule

// File: rtl/exmpipe.sv
// Execute stage with forwarding, iterative MUL sequencing, and the E/M pipeline register.
// Optional condition flags on the E/M register are enabled with EXMPIPE_FLAGS_EN.
module exmpipe
  import proc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_M,
  input  logic         regw_E,
  input  logic         memw_E,
  input  logic         regmem_E,
  input  logic         ALUope_E,
  input  logic [L-1:0] ALUctrl_E,
  input  logic [M-1:0] regScr_E,
  input  logic [N-1:0] regA_E,
  input  logic [N-1:0] regB_E,
  input  logic [N-1:0] inm_E,
  input  logic [1:0]   fwdA_sel,
  input  logic [1:0]   fwdB_sel,
  input  logic [N-1:0] result_W,
  output logic         stall_E,
  output logic         regw_M,
  output logic         memw_M,
  output logic         regmem_M,
  output logic [M-1:0] regScr_M,
  output logic [N-1:0] aluout_M,
  output logic [N-1:0] wdata_M
`ifdef EXMPIPE_FLAGS_EN
  ,
  output logic         zero_M,
  output logic         neg_M,
  output logic         carry_M
`endif
);

  exm_state_t   state_q, state_d;
  em_t          em_q, em_d;
  mul_ctl_t     ctl_q, ctl_d;
  alu_op_t      op_c;
  logic [N-1:0] opa_c, regbf_c, opb_c, alu_c, product_c;
  logic         mul_start_c, mul_last_c;

  // Operand forwarding and single-cycle ALU
  always_comb begin
    op_c    = alu_op_t'(ALUctrl_E);
    opa_c   = fwd_mux(fwdA_sel, regA_E, em_q.aluout, result_W);
    regbf_c = fwd_mux(fwdB_sel, regB_E, em_q.aluout, result_W);
    opb_c   = ALUope_E ? inm_E : regbf_c;
    alu_c   = alu_eval(op_c, opa_c, opb_c);
  end

  mul_iter u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_c),
    .a       (opa_c),
    .b       (opb_c),
    .done_c  (mul_last_c),
    .product (product_c)
  );

  // Sequencing: E/M gets a bubble unless a result is being retired this cycle
  always_comb begin
    state_d     = state_q;
    ctl_d       = ctl_q;
    em_d        = '0;
    stall_E     = 1'b0;
    mul_start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_c == ALU_MUL) begin
          stall_E      = rst;
          mul_start_c  = 1'b1;
          ctl_d.regw   = regw_E;
          ctl_d.memw   = memw_E;
          ctl_d.regmem = regmem_E;
          ctl_d.regscr = regScr_E;
          ctl_d.wdata  = regbf_c;
          state_d      = BUSY;
        end else begin
          em_d.regw   = regw_E;
          em_d.memw   = memw_E;
          em_d.regmem = regmem_E;
          em_d.regscr = regScr_E;
          em_d.aluout = alu_c;
          em_d.wdata  = regbf_c;
        end
      end
      BUSY: begin
        stall_E = rst;
        if (mul_last_c) state_d = DONE;
      end
      DONE: begin
        em_d.regw   = ctl_q.regw;
        em_d.memw   = ctl_q.memw;
        em_d.regmem = ctl_q.regmem;
        em_d.regscr = ctl_q.regscr;
        em_d.aluout = product_c;
        em_d.wdata  = ctl_q.wdata;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_M) begin
      em_d.regw   = 1'b0;
      em_d.memw   = 1'b0;
      em_d.regmem = 1'b0;
      em_d.regscr = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      em_q    <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      em_q    <= em_d;
      ctl_q   <= ctl_d;
    end
  end

  assign regw_M   = em_q.regw;
  assign memw_M   = em_q.memw;
  assign regmem_M = em_q.regmem;
  assign regScr_M = em_q.regscr;
  assign aluout_M = em_q.aluout;
  assign wdata_M  = em_q.wdata;

`ifdef EXMPIPE_FLAGS_EN
  logic [2:0] flg_q, flg_d;  // {zero, neg, carry}

  // Flags follow the captured result; bubbles and flushes clear them
  always_comb begin
    flg_d = '0;
    if (!flush_M) begin
      if (state_q == IDLE && op_c != ALU_MUL) begin
        flg_d[2] = (alu_c == '0);
        flg_d[1] = alu_c[N-1];
        flg_d[0] = alu_carry(op_c, opa_c, opb_c);
      end else if (state_q == DONE) begin
        flg_d[2] = (product_c == '0);
        flg_d[1] = product_c[N-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flg_q <= '0;
    else      flg_q <= flg_d;
  end

  assign zero_M  = flg_q[2];
  assign neg_M   = flg_q[1];
  assign carry_M = flg_q[0];
`endif

endmodule

// File: tb/tb_exmpipe.sv
// Scoreboard bench for exmpipe: a driver pushes expected E/M contents per cycle, a monitor pops and compares.
module tb_exmpipe;

  localparam int W = 32;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] ra, rb, inm, resw;
    logic        imm, rw, mw, rm, flush;
    logic [1:0]  fa, fb;
    logic [3:0]  rd;
  } ins_t;

  typedef struct {
    logic        rw, mw, rm;
    logic [3:0]  rd;
    logic [31:0] alu, wd;
    logic [2:0]  flg;
    logic        chk_data;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_M = 1'b0;
  logic        regw_E = 1'b0, memw_E = 1'b0, regmem_E = 1'b0, ALUope_E = 1'b0;
  logic [2:0]  ALUctrl_E = '0;
  logic [3:0]  regScr_E = '0;
  logic [31:0] regA_E = '0, regB_E = '0, inm_E = '0, result_W = '0;
  logic [1:0]  fwdA_sel = '0, fwdB_sel = '0;
  logic        stall_E, regw_M, memw_M, regmem_M;
  logic [3:0]  regScr_M;
  logic [31:0] aluout_M, wdata_M;
`ifdef EXMPIPE_FLAGS_EN
  logic        zero_M, neg_M, carry_M;
`endif

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];
  logic [31:0] model_alu = '0;
  bit   model_known = 1'b1;

  exmpipe dut (
    .clk(clk), .rst(rst), .flush_M(flush_M),
    .regw_E(regw_E), .memw_E(memw_E), .regmem_E(regmem_E), .ALUope_E(ALUope_E),
    .ALUctrl_E(ALUctrl_E), .regScr_E(regScr_E),
    .regA_E(regA_E), .regB_E(regB_E), .inm_E(inm_E),
    .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel), .result_W(result_W),
    .stall_E(stall_E), .regw_M(regw_M), .memw_M(memw_M), .regmem_M(regmem_M),
    .regScr_M(regScr_M), .aluout_M(aluout_M), .wdata_M(wdata_M)
`ifdef EXMPIPE_FLAGS_EN
    , .zero_M(zero_M), .neg_M(neg_M), .carry_M(carry_M)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  // Reference behaviour written from the instruction semantics
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << (b % 32);
      3'd6: return a >> (b % 32);
      default: return a * b;
    endcase
  endfunction

  function automatic logic [2:0] ref_flags(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] r);
    logic c;
    longint sum;
    sum = longint'(a) + longint'(b);
    if (op == 3'd0)      c = (sum > 64'h0000_0000_FFFF_FFFF);
    else if (op == 3'd1) c = (a >= b);
    else                 c = 1'b0;
    return {r == 32'd0, r[31], c};
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] regv,
                                      input logic [31:0] wb);
    if (sel == 2'd1) return model_alu;
    if (sel == 2'd2) return wb;
    return regv;
  endfunction

  function automatic ins_t mk(input logic [2:0] op, input logic [31:0] ra, input logic [31:0] rb,
                              input logic imm, input logic [31:0] inm, input logic [1:0] fa,
                              input logic [1:0] fb, input logic [31:0] resw, input logic rw,
                              input logic mw, input logic [3:0] rd, input logic flush);
    ins_t i;
    i.op = op; i.ra = ra; i.rb = rb; i.imm = imm; i.inm = inm; i.fa = fa; i.fb = fb;
    i.resw = resw; i.rw = rw; i.mw = mw; i.rm = 1'b0; i.rd = rd; i.flush = flush;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    i.op   = 3'($urandom_range(0, 7));
    i.ra   = $urandom;
    i.rb   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    i.inm  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    i.resw = $urandom;
    i.imm  = 1'($urandom);
    i.fa   = 2'($urandom);
    i.fb   = 2'($urandom);
    if (!model_known && i.fa == 2'd1) i.fa = 2'd0;
    if (!model_known && i.fb == 2'd1) i.fb = 2'd0;
    i.rw    = 1'($urandom);
    i.mw    = 1'($urandom);
    i.rm    = 1'($urandom);
    i.rd    = 4'($urandom);
    i.flush = ($urandom_range(0, 7) == 0);
    return i;
  endfunction

  task automatic drive(input ins_t i);
    ALUctrl_E = i.op; regA_E = i.ra; regB_E = i.rb; inm_E = i.inm; result_W = i.resw;
    ALUope_E = i.imm; fwdA_sel = i.fa; fwdB_sel = i.fb;
    regw_E = i.rw; memw_E = i.mw; regmem_E = i.rm; regScr_E = i.rd;
  endtask

  task automatic push_result(input exp_t e, input logic fl);
    if (fl) begin
      e.rw = 1'b0; e.mw = 1'b0; e.rm = 1'b0; e.rd = '0; e.flg = '0; e.chk_data = 1'b0;
      model_known = 1'b0;
    end else begin
      model_alu = e.alu;
      model_known = 1'b1;
    end
    q.push_back(e);
  endtask

  task automatic push_bubble(input string tag);
    exp_t e;
    e.rw = 1'b0; e.mw = 1'b0; e.rm = 1'b0; e.rd = '0; e.alu = '0; e.wd = '0; e.flg = '0;
    e.chk_data = 1'b1; e.tag = tag;
    model_alu = '0;
    model_known = 1'b1;
    q.push_back(e);
  endtask

  // Present one instruction at a negedge; returns at the negedge after it has retired
  task automatic issue(input ins_t i, input string tag);
    logic [31:0] oa, bf, ob, r;
    exp_t e;
    int stalls;
    drive(i);
    flush_M = (i.op == 3'd7) ? 1'b0 : i.flush;
    oa = fwd(i.fa, i.ra, i.resw);
    bf = fwd(i.fb, i.rb, i.resw);
    ob = i.imm ? i.inm : bf;
    r  = ref_alu(i.op, oa, ob);
    e.rw = i.rw; e.mw = i.mw; e.rm = i.rm; e.rd = i.rd; e.alu = r; e.wd = bf;
    e.flg = (i.op == 3'd7) ? {r == 32'd0, r[31], 1'b0} : ref_flags(i.op, oa, ob, r);
    e.chk_data = 1'b1; e.tag = tag;
    if (i.op != 3'd7) begin
      #1;
      chk({tag, " stall_E"}, 32'(stall_E), 32'd0);
      push_result(e, i.flush);
      @(negedge clk);
    end else begin
      stalls = 0;
      for (int k = 0; k <= W; k++) begin
        if (k > 0) begin
          drive(rand_ins());
          flush_M = 1'b0;
        end
        #1;
        if (stall_E) stalls++;
        chk({tag, " stall_E busy"}, 32'(stall_E), 32'd1);
        push_bubble({tag, " bubble"});
        @(negedge clk);
      end
      drive(rand_ins());
      flush_M = i.flush;
      #1;
      chk({tag, " stall_E done"}, 32'(stall_E), 32'd0);
      push_result(e, i.flush);
      @(negedge clk);
      chk({tag, " stall cycles"}, 32'(stalls), 32'(W + 1));
    end
  endtask

  // Monitor: one E/M expectation per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, " regw_M"}, 32'(regw_M), 32'(e.rw));
        chk({e.tag, " memw_M"}, 32'(memw_M), 32'(e.mw));
        chk({e.tag, " regmem_M"}, 32'(regmem_M), 32'(e.rm));
        chk({e.tag, " regScr_M"}, 32'(regScr_M), 32'(e.rd));
        if (e.chk_data) begin
          chk({e.tag, " aluout_M"}, aluout_M, e.alu);
          chk({e.tag, " wdata_M"}, wdata_M, e.wd);
        end
`ifdef EXMPIPE_FLAGS_EN
        chk({e.tag, " flags"}, 32'({zero_M, neg_M, carry_M}), 32'(e.flg));
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    ins_t z;
    z = mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held with random inputs
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(rand_ins());
      ALUctrl_E = (k == 0) ? 3'd7 : ALUctrl_E;
      flush_M = 1'b0;
      #1;
      chk("reset stall_E", 32'(stall_E), 32'd0);
      chk("reset ctrl", 32'({regw_M, memw_M, regmem_M}), 32'd0);
      chk("reset regScr_M", 32'(regScr_M), 32'd0);
      chk("reset aluout_M", aluout_M, 32'd0);
      chk("reset wdata_M", wdata_M, 32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    mon_en = 1'b1;
    model_alu = '0;
    model_known = 1'b1;

    issue(mk(3'd0, 5, 7, 0, 0, 0, 0, 0, 1, 0, 3, 0), "add5+7");
    issue(mk(3'd1, 99, 0, 1, 4, 1, 0, 0, 1, 0, 5, 0), "fwdA sub imm");
    issue(mk(3'd0, 1, 32'h55, 0, 0, 0, 2, 32'hAA, 0, 1, 6, 0), "fwdB store");
    issue(mk(3'd7, 123, 456, 0, 0, 0, 0, 0, 1, 0, 7, 0), "mul123x456");
    issue(mk(3'd7, 32'hFFFF_FFFF, 2, 1, 2, 0, 0, 0, 1, 0, 8, 0), "mulFFx2");
    issue(mk(3'd5, 1, 0, 1, 32'h21, 0, 0, 0, 1, 0, 2, 0), "sll wrap");
    issue(mk(3'd6, 32'h8000_0000, 31, 0, 0, 0, 0, 0, 1, 0, 2, 0), "srl31");
    issue(mk(3'd7, 3, 9, 0, 0, 0, 0, 0, 1, 0, 9, 1), "mul flush");
    issue(mk(3'd0, 2, 2, 0, 0, 0, 0, 0, 1, 0, 4, 0), "after flush");
    issue(mk(3'd1, 5, 5, 0, 0, 0, 0, 0, 1, 0, 1, 0), "sub5-5");
    issue(mk(3'd1, 3, 5, 0, 0, 0, 0, 0, 1, 0, 1, 0), "sub3-5");
    issue(z, "de bubble");

    for (int n = 0; n < 200; n++) issue(rand_ins(), "rnd");

    // Asynchronous reset in the middle of a multiply
    mon_en = 1'b0;
    drive(mk(3'd7, 11, 13, 0, 0, 0, 0, 0, 1, 0, 7, 0));
    flush_M = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midmul rst stall_E", 32'(stall_E), 32'd0);
    chk("midmul rst regw_M", 32'(regw_M), 32'd0);
    chk("midmul rst aluout_M", aluout_M, 32'd0);
    drive(z);
    @(negedge clk);
    rst = 1'b1;
    model_alu = '0;
    model_known = 1'b1;
    mon_en = 1'b1;
    issue(mk(3'd0, 40, 2, 0, 0, 0, 0, 0, 1, 0, 10, 0), "post rst add");
    issue(mk(3'd7, 7, 6, 0, 0, 1, 0, 0, 1, 0, 11, 0), "post rst mul");

    drive(z);
    flush_M = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
